// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage data-memory initiator (req/ack bus, stall, mdr)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic [DATA_W-1:0] mdr_o,
   output logic              stall_o,
   output logic              mem_wb_en_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] C_ERR_RW       = 2'b10;
   localparam logic [1:0] C_ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              stall;
   logic              access;

   assign access = mem_valid_i & (mem_read_i | mem_write_i);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mdr_d      = mdr_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      stall      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (access) begin
               // Read&write is checked first so it wins over misalignment.
               if (mem_read_i && mem_write_i) begin
                  err_d      = 1'b1;
                  err_code_d = C_ERR_RW;
               end else if (addr_i[1:0] != 2'b00) begin
                  err_d      = 1'b1;
                  err_code_d = C_ERR_MISALIGN;
               end else begin
                  stall   = 1'b1;
                  addr_d  = addr_i;
                  wdata_d = wdata_i;
                  we_d    = mem_write_i;
                  cnt_d   = '0;
                  state_d = ST_BUSY;
               end
            end
         end

         ST_BUSY: begin
            stall = 1'b1;
            if (bus_ack_i) begin
               if (!we_q) mdr_d = bus_rdata_i;
               state_d = ST_DONE;
            end else if (cnt_q == C_CNT_LAST) begin
               if (!we_q) mdr_d = '0;
               err_d      = 1'b1;
               err_code_d = C_ERR_TIMEOUT;
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            // EX_MEM still shows the completed op here, so inputs are ignored.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mdr_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mdr_q      <= mdr_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus_req_o   = (state_q == ST_BUSY);
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_wdata_o = wdata_q;
   assign mdr_o       = mdr_q;
   assign stall_o     = stall;
   assign mem_wb_en_o = ~stall;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : directed self-checking bench for mem_access_ctrl
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i, mem_read_i, mem_write_i;
   logic [31:0] addr_i, wdata_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic [31:0] mdr_o;
   logic        stall_o, mem_wb_en_o, err_o;
   logic [1:0]  err_code_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   mem_access_ctrl #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid_i(mem_valid_i),
      .mem_read_i (mem_read_i),
      .mem_write_i(mem_write_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .bus_req_o  (bus_req_o),
      .bus_we_o   (bus_we_o),
      .bus_addr_o (bus_addr_o),
      .bus_wdata_o(bus_wdata_o),
      .bus_ack_i  (bus_ack_i),
      .bus_rdata_i(bus_rdata_i),
      .mdr_o      (mdr_o),
      .stall_o    (stall_o),
      .mem_wb_en_o(mem_wb_en_o),
      .err_o      (err_o),
      .err_code_o (err_code_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_valid_i = 1'b0;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      addr_i      = '0;
      wdata_i     = '0;
   endtask

   // Presents one op and walks it to its DONE cycle. ack_k = BUSY cycle of the
   // ack (0 = never ack). Returns at DONE with the op still presented.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_k, input logic [31:0] rdat,
                             output int stall_n, output int req_n, output logic stable);
      logic ended;
      mem_valid_i = 1'b1;
      mem_read_i  = rd;
      mem_write_i = wr;
      addr_i      = a;
      wdata_i     = wd;
      bus_ack_i   = 1'b0;
      stall_n     = 0;
      req_n       = 0;
      stable      = 1'b1;
      ended       = 1'b0;
      #1;
      for (int c = 0; c < 32 && !ended; c++) begin
         if (bus_req_o) begin
            req_n++;
            if (bus_addr_o !== a || bus_wdata_o !== wd || bus_we_o !== wr) stable = 1'b0;
            if (req_n == ack_k) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = rdat;
            end
         end
         if (stall_o) begin
            stall_n++;
            tick();
            bus_ack_i = 1'b0;
         end else begin
            ended = 1'b1;
         end
      end
      check("access_ends", {31'd0, ended}, 32'd1);
   endtask

   int   s_n, r_n, t0, t1;
   logic stab;

   initial begin
      rst = 1'b0;
      clear_inputs();
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      repeat (2) tick();
      check("rst_req",   {31'd0, bus_req_o}, 32'd0);
      check("rst_mdr",   mdr_o, 32'd0);
      check("rst_addr",  bus_addr_o, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_code",  {30'd0, err_code_o}, 32'd0);
      rst = 1'b1;
      tick();

      // Read with ack in 3rd BUSY cycle
      run_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D, s_n, r_n, stab);
      check("rd_stall_n", s_n, 32'd4);
      check("rd_req_n",   r_n, 32'd3);
      check("rd_stable",  {31'd0, stab}, 32'd1);
      check("rd_mdr",     mdr_o, 32'hCAFEF00D);
      check("rd_wb_en",   {31'd0, mem_wb_en_o}, 32'd1);
      check("rd_done_req", {31'd0, bus_req_o}, 32'd0);
      clear_inputs();
      tick();

      // Write with ack in 1st BUSY cycle
      run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 1, 32'hBADBAD00, s_n, r_n, stab);
      check("wr_stall_n", s_n, 32'd2);
      check("wr_stable",  {31'd0, stab}, 32'd1);
      check("wr_we",      {31'd0, bus_we_o}, 32'd1);
      check("wr_wdata",   bus_wdata_o, 32'h12345678);
      check("wr_mdr",     mdr_o, 32'hCAFEF00D);
      clear_inputs();
      tick();

      // Misaligned read
      mem_valid_i = 1'b1; mem_read_i = 1'b1; addr_i = 32'h102;
      #1;
      check("mis_stall", {31'd0, stall_o}, 32'd0);
      check("mis_wb_en", {31'd0, mem_wb_en_o}, 32'd1);
      check("mis_req0",  {31'd0, bus_req_o}, 32'd0);
      tick();
      clear_inputs();
      check("mis_err",   {31'd0, err_o}, 32'd1);
      check("mis_code",  {30'd0, err_code_o}, 32'd1);
      check("mis_req1",  {31'd0, bus_req_o}, 32'd0);
      tick();
      check("mis_err_pulse", {31'd0, err_o}, 32'd0);
      check("mis_code_hold", {30'd0, err_code_o}, 32'd1);

      // Read&write on a misaligned address: read&write code wins
      mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b1; addr_i = 32'h103;
      #1;
      check("rw_stall", {31'd0, stall_o}, 32'd0);
      tick();
      clear_inputs();
      check("rw_err",  {31'd0, err_o}, 32'd1);
      check("rw_code", {30'd0, err_code_o}, 32'd2);
      tick();

      // Timeout read, no ack
      run_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0, s_n, r_n, stab);
      check("to_req_n",   r_n, 32'd4);
      check("to_stall_n", s_n, 32'd5);
      check("to_err",     {31'd0, err_o}, 32'd1);
      check("to_code",    {30'd0, err_code_o}, 32'd3);
      check("to_mdr",     mdr_o, 32'd0);
      clear_inputs();
      tick();
      check("to_err_pulse", {31'd0, err_o}, 32'd0);

      // Spurious ack in IDLE
      bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
      tick();
      bus_ack_i = 1'b0;
      check("sp_idle_mdr", mdr_o, 32'd0);
      check("sp_idle_req", {31'd0, bus_req_o}, 32'd0);

      // Back-to-back reads with a spurious ack in DONE
      t0 = cyc;
      run_access(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h11111111, s_n, r_n, stab);
      check("b2b_mdr0", mdr_o, 32'h11111111);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
      addr_i = 32'h404;
      #1;
      check("b2b_done_stall", {31'd0, stall_o}, 32'd0);
      tick();
      bus_ack_i = 1'b0;
      check("b2b_sp_done_mdr", mdr_o, 32'h11111111);
      t1 = cyc;
      check("b2b_spacing", t1 - t0, 32'd3);
      run_access(1'b1, 1'b0, 32'h404, 32'h0, 2, 32'h22222222, s_n, r_n, stab);
      check("b2b_mdr1",    mdr_o, 32'h22222222);
      check("b2b_stall_n", s_n, 32'd3);
      clear_inputs();
      tick();

      // Reset in the middle of BUSY
      mem_valid_i = 1'b1; mem_read_i = 1'b1; addr_i = 32'h500;
      tick();
      tick();
      check("mr_busy_req", {31'd0, bus_req_o}, 32'd1);
      rst = 1'b0;
      clear_inputs();
      tick();
      check("mr_req_next", {31'd0, bus_req_o}, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      check("mr_mdr",   mdr_o, 32'd0);
      check("mr_stall", {31'd0, stall_o}, 32'd0);
      check("mr_code",  {30'd0, err_code_o}, 32'd0);
      check("mr_err",   {31'd0, err_o}, 32'd0);
      tick();
      check("mr_idle_req", {31'd0, bus_req_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
